// File: rtl/cdc_handshake_src_if.sv
// Bundle for the source side of the 4-phase req/ack crossing: word intake,
// held bundle to the far domain, and status.
interface cdc_handshake_src_if #(
    parameter int DATA_WIDTH = 4096
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] hs_data;
    logic                  hs_req;
    logic                  hs_ack;
    logic                  busy;
    logic                  timeout_err;
    logic                  err_clr;
    logic [31:0]           xfer_cnt;

    modport master (
        input  in_data, in_valid, hs_ack, err_clr,
        output in_ready, hs_data, hs_req, busy, timeout_err, xfer_cnt
    );

    modport slave (
        output in_data, in_valid, hs_ack, err_clr,
        input  in_ready, hs_data, hs_req, busy, timeout_err, xfer_cnt
    );
endinterface

// File: rtl/cdc_handshake_src.sv
// Source-side initiator of the 4-phase level handshake: latches a word, raises
// hs_req, waits for the synchronised ack to rise and fall, with per-phase timeout.
module cdc_handshake_src #(
    parameter int DATA_WIDTH     = 4096,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                resetb,
    cdc_handshake_src_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    state_t                  state_r;
    state_t                  next_state_s;
    logic [SYNC_STAGES-1:0]  ack_sync_r;
    logic                    ack_s;
    logic [TMO_W-1:0]        tmo_cnt_r;
    logic                    tmo_hit_s;
    logic                    hs_req_r;
    logic [DATA_WIDTH-1:0]   hs_data_r;
    logic                    timeout_err_r;
    logic [31:0]             xfer_cnt_r;
    logic                    abort_r;

    logic                    load_data_s;
    logic                    req_next_s;
    logic                    set_err_s;
    logic                    inc_cnt_s;
    logic                    set_abort_s;

    assign ack_s     = ack_sync_r[SYNC_STAGES-1];
    assign tmo_hit_s = TMO_EN && (tmo_cnt_r == TMO_LAST);

    // hs_ack synchroniser; only its last stage feeds the FSM
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ack_sync_r <= '0;
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], bus.hs_ack};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state: an arriving ack takes priority over the timeout limit
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                next_state_s = ST_REQ;
            end
            ST_REQ: begin
                if (ack_s || tmo_hit_s) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_RELEASE: begin
                if (!ack_s || tmo_hit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RELEASE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: next values and enables for the registered datapath
    always_comb begin
        load_data_s = 1'b0;
        req_next_s  = hs_req_r;
        set_err_s   = 1'b0;
        inc_cnt_s   = 1'b0;
        set_abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_data_s = bus.in_valid;
                req_next_s  = 1'b0;
            end
            ST_SETUP: begin
                req_next_s = 1'b1;
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_next_s = 1'b0;
                end else if (tmo_hit_s) begin
                    req_next_s  = 1'b0;
                    set_err_s   = 1'b1;
                    set_abort_s = 1'b1;
                end else begin
                    req_next_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                req_next_s = 1'b0;
                if (!ack_s) begin
                    inc_cnt_s = !abort_r;
                end else if (tmo_hit_s) begin
                    set_err_s = 1'b1;
                end else begin
                    set_err_s = 1'b0;
                end
            end
            default: begin
                req_next_s = 1'b0;
            end
        endcase
    end

    // Wait-state timeout counter: restarts whenever the state changes
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tmo_cnt_r <= '0;
        end else if (!TMO_EN || (next_state_s != state_r)) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_REQ) || (state_r == ST_RELEASE)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
    end

    // Held bundle and level request toward the far domain
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            hs_data_r <= '0;
            hs_req_r  <= 1'b0;
        end else begin
            if (load_data_s) begin
                hs_data_r <= bus.in_data;
            end
            hs_req_r <= req_next_s;
        end
    end

    // Status: sticky error (set beats clear), abort marker, transfer count
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            timeout_err_r <= 1'b0;
            abort_r       <= 1'b0;
            xfer_cnt_r    <= 32'd0;
        end else begin
            if (set_err_s) begin
                timeout_err_r <= 1'b1;
            end else if (bus.err_clr) begin
                timeout_err_r <= 1'b0;
            end
            if (set_abort_s) begin
                abort_r <= 1'b1;
            end else if (state_r == ST_IDLE) begin
                abort_r <= 1'b0;
            end
            if (inc_cnt_s) begin
                xfer_cnt_r <= xfer_cnt_r + 32'd1;
            end
        end
    end

    assign bus.in_ready    = (state_r == ST_IDLE);
    assign bus.busy        = (state_r != ST_IDLE);
    assign bus.hs_data     = hs_data_r;
    assign bus.hs_req      = hs_req_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.xfer_cnt    = xfer_cnt_r;

endmodule
